// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the writeback slice: widths, writeback FSM states, load funct3 codes.
package rv32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_REG = 32;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects byte/half/word by offset, extends it, and flags misaligned or illegal loads.
module load_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        data     = '0;
        err      = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(XLEN-16){half_sel[15]}}, half_sel};
                err  = addr_lo[0];
            end
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, half_sel};
                err  = addr_lo[0];
            end
            F3_LW: begin
                data = word;
                err  = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: sole register-file write master, waits on load responses and exports the pending-load entry.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module writeback_unit
    import rv32_pkg::*;
#(
    parameter int unsigned data_width = XLEN,
    parameter int unsigned num_reg    = NUM_REG,
    parameter int unsigned idx_width  = $clog2(num_reg)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [idx_width-1:0]  in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [data_width-1:0] in_result,
    input  logic                  mem_rsp_valid,
    input  logic [data_width-1:0] mem_rsp_data,
    output logic                  rf_wen,
    output logic [idx_width-1:0]  rf_rd,
    output logic [data_width-1:0] rf_rdv,
    output logic                  pend_valid,
    output logic [idx_width-1:0]  pend_rd,
    output logic                  ld_err
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]           instret
`endif
);

    wb_state_t             state, state_n;
    logic                  rf_wen_n, pend_valid_n, ld_err_n;
    logic [idx_width-1:0]  rf_rd_n, pend_rd_n;
    logic [data_width-1:0] rf_rdv_n;
    logic [idx_width-1:0]  lat_rd, lat_rd_n;
    logic                  lat_wen, lat_wen_n;
    logic [2:0]            lat_f3, lat_f3_n;
    logic [1:0]            lat_lo, lat_lo_n;
    logic [XLEN-1:0]       al_data;
    logic                  al_err;

    load_align u_align (
        .funct3  (lat_f3),
        .addr_lo (lat_lo),
        .word    (XLEN'(mem_rsp_data)),
        .data    (al_data),
        .err     (al_err)
    );

    assign in_ready = (state == IDLE);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rf_wen     <= 1'b0;
            rf_rd      <= '0;
            rf_rdv     <= '0;
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            ld_err     <= 1'b0;
            lat_rd     <= '0;
            lat_wen    <= 1'b0;
            lat_f3     <= '0;
            lat_lo     <= '0;
        end else begin
            state      <= state_n;
            rf_wen     <= rf_wen_n;
            rf_rd      <= rf_rd_n;
            rf_rdv     <= rf_rdv_n;
            pend_valid <= pend_valid_n;
            pend_rd    <= pend_rd_n;
            ld_err     <= ld_err_n;
            lat_rd     <= lat_rd_n;
            lat_wen    <= lat_wen_n;
            lat_f3     <= lat_f3_n;
            lat_lo     <= lat_lo_n;
        end
    end

    // Next state and next outputs; rf_rd/rf_rdv only move on a real write
    always_comb begin
        state_n      = state;
        rf_wen_n     = 1'b0;
        rf_rd_n      = rf_rd;
        rf_rdv_n     = rf_rdv;
        pend_valid_n = pend_valid;
        pend_rd_n    = pend_rd;
        ld_err_n     = 1'b0;
        lat_rd_n     = lat_rd;
        lat_wen_n    = lat_wen;
        lat_f3_n     = lat_f3;
        lat_lo_n     = lat_lo;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        lat_rd_n     = in_rd;
                        lat_wen_n    = in_wen;
                        lat_f3_n     = in_funct3;
                        lat_lo_n     = in_addr_lo;
                        pend_valid_n = in_wen && (in_rd != '0);
                        pend_rd_n    = in_rd;
                        state_n      = WAIT_MEM;
                    end else if (in_wen && (in_rd != '0)) begin
                        rf_wen_n = 1'b1;
                        rf_rd_n  = in_rd;
                        rf_rdv_n = in_result;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    pend_valid_n = 1'b0;
                    state_n      = IDLE;
                    if (al_err) begin
                        ld_err_n = 1'b1;
                    end else if (lat_wen && (lat_rd != '0)) begin
                        rf_wen_n = 1'b1;
                        rf_rd_n  = lat_rd;
                        rf_rdv_n = data_width'(al_data);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef WB_INSTRET_EN
    logic retire_c;

    // Every accepted non-load and every load response retires one instruction
    assign retire_c = ((state == IDLE) && in_valid && !in_is_load) ||
                      ((state == WAIT_MEM) && mem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire_c) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: vector table, write scoreboard, reset/back-to-back sequences, standalone load_align.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rdv;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        ld_err;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [31:0] al_word;
    logic [31:0] al_data;
    logic        al_err;

    writeback_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wen        (in_wen),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_result     (in_result),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rf_wen        (rf_wen),
        .rf_rd         (rf_rd),
        .rf_rdv        (rf_rdv),
        .pend_valid    (pend_valid),
        .pend_rd       (pend_rd),
        .ld_err        (ld_err)
`ifdef WB_INSTRET_EN
        ,
        .instret       (instret)
`endif
    );

    load_align u_al (
        .funct3  (al_f3),
        .addr_lo (al_lo),
        .word    (al_word),
        .data    (al_data),
        .err     (al_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] val;
        logic        exp_wr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    localparam int unsigned NVEC = 14;
    vec_t vecs [NVEC];
    wr_t  exp_q [$];
    wr_t  exp_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, required no write", rf_rd, rf_rdv);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_rd", 64'(rf_rd), 64'(exp_e.rd));
                check("wr_data", 64'(rf_rdv), 64'(exp_e.data));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
        in_funct3 = '0; in_addr_lo = '0; in_result = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        al_f3 = '0; al_lo = '0; al_word = '0;

        //          load  rd     wen  f3      lo     value          wr    expected       err
        vecs[0]  = '{1'b0, 5'd5,  1'b1, 3'b000, 2'd0, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  1'b1, 3'b000, 2'd0, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 5'd9,  1'b0, 3'b000, 2'd0, 32'h1111_2222, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 5'd7,  1'b1, 3'b000, 2'd2, 32'h0080_0000, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b1, 5'd8,  1'b1, 3'b101, 2'd2, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 5'd8,  1'b1, 3'b001, 2'd2, 32'hBEEF_0000, 1'b1, 32'hFFFF_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 5'd3,  1'b1, 3'b100, 2'd3, 32'h9A00_0000, 1'b1, 32'h0000_009A, 1'b0};
        vecs[7]  = '{1'b1, 5'd4,  1'b1, 3'b010, 2'd0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, 5'd4,  1'b1, 3'b010, 2'd1, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 5'd6,  1'b1, 3'b001, 2'd1, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
        vecs[10] = '{1'b1, 5'd6,  1'b1, 3'b011, 2'd0, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
        vecs[11] = '{1'b1, 5'd0,  1'b1, 3'b000, 2'd0, 32'h0000_007F, 1'b0, 32'h0000_007F, 1'b0};
        vecs[12] = '{1'b1, 5'd6,  1'b1, 3'b001, 2'd0, 32'h1234_8001, 1'b1, 32'hFFFF_8001, 1'b0};
        vecs[13] = '{1'b1, 5'd10, 1'b1, 3'b000, 2'd1, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0};

        // Reset state
        step();
        check("in_ready_in_reset", 64'(in_ready), 64'd1);
        step();
        check("rst_rf_wen", 64'(rf_wen), 64'd0);
        check("rst_rf_rd", 64'(rf_rd), 64'd0);
        check("rst_rf_rdv", 64'(rf_rdv), 64'd0);
        check("rst_pend_valid", 64'(pend_valid), 64'd0);
        check("rst_pend_rd", 64'(pend_rd), 64'd0);
        check("rst_ld_err", 64'(ld_err), 64'd0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 64'd0);
`endif
        rst_n = 1'b1;

        // Standalone aligner
        for (int i = 0; i < int'(NVEC); i++) begin
            if (vecs[i].is_load) begin
                al_f3 = vecs[i].f3; al_lo = vecs[i].lo; al_word = vecs[i].val;
                #1;
                check($sformatf("align_err_%0d", i), 64'(al_err), 64'(vecs[i].exp_err));
                if (!vecs[i].exp_err)
                    check($sformatf("align_data_%0d", i), 64'(al_data), 64'(vecs[i].exp_data));
            end
        end

        // Vector table through the full unit
        for (int i = 0; i < int'(NVEC); i++) begin
            in_valid = 1'b1; in_rd = vecs[i].rd; in_wen = vecs[i].wen;
            in_is_load = vecs[i].is_load; in_funct3 = vecs[i].f3; in_addr_lo = vecs[i].lo;
            in_result = vecs[i].is_load ? 32'h0 : vecs[i].val;
            if (!vecs[i].is_load && vecs[i].exp_wr) exp_q.push_back('{vecs[i].rd, vecs[i].exp_data});
            step();
            in_valid = 1'b0;
            if (!vecs[i].is_load) begin
                step();
                check($sformatf("wen_pulse_%0d", i), 64'(rf_wen), 64'd0);
            end else begin
                check($sformatf("wait_ready_%0d", i), 64'(in_ready), 64'd0);
                check($sformatf("wait_pend_%0d", i), 64'(pend_valid), 64'(vecs[i].wen && vecs[i].rd != 5'd0));
                if (vecs[i].rd != 5'd0) check($sformatf("wait_pend_rd_%0d", i), 64'(pend_rd), 64'(vecs[i].rd));
                step();
                check($sformatf("wait_hold_%0d", i), 64'(in_ready), 64'd0);
                mem_rsp_valid = 1'b1; mem_rsp_data = vecs[i].val;
                if (vecs[i].exp_wr) exp_q.push_back('{vecs[i].rd, vecs[i].exp_data});
                step();
                mem_rsp_valid = 1'b0; mem_rsp_data = '0;
                check($sformatf("rsp_ld_err_%0d", i), 64'(ld_err), 64'(vecs[i].exp_err));
                check($sformatf("rsp_pend_clr_%0d", i), 64'(pend_valid), 64'd0);
                check($sformatf("rsp_ready_%0d", i), 64'(in_ready), 64'd1);
                step();
                check($sformatf("ld_err_pulse_%0d", i), 64'(ld_err), 64'd0);
                check($sformatf("wen_pulse_%0d", i), 64'(rf_wen), 64'd0);
            end
        end

        // Reset while a load is outstanding, then a stray response
        in_valid = 1'b1; in_rd = 5'd11; in_wen = 1'b1; in_is_load = 1'b1;
        in_funct3 = 3'b010; in_addr_lo = 2'd0;
        step();
        in_valid = 1'b0;
        check("midrst_pend_before", 64'(pend_valid), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_pend_after", 64'(pend_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
`ifdef WB_INSTRET_EN
        check("midrst_instret", instret, 64'd0);
`endif
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
        step();
        mem_rsp_valid = 1'b0;
        check("stray_rf_wen", 64'(rf_wen), 64'd0);
        check("stray_pend", 64'(pend_valid), 64'd0);
        check("stray_ready", 64'(in_ready), 64'd1);

        // Back-to-back ALU accepts
        in_valid = 1'b1; in_wen = 1'b1; in_is_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_rd = 5'(12 + k);
            in_result = 32'hA000_0000 + 32'(k);
            exp_q.push_back('{5'(12 + k), 32'hA000_0000 + 32'(k)});
            check($sformatf("b2b_ready_%0d", k), 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        check("b2b_idle_wen", 64'(rf_wen), 64'd0);
`ifdef WB_INSTRET_EN
        check("instret_three", instret, 64'd3);
`endif

        step();
        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
